// File: rtl/i2s_receiver_if.sv
// I2S receiver bus: serial pins in, deserialized stereo/mono samples and link status out.
interface i2s_receiver_if #(
   parameter int unsigned RESBIT = 8
);
   logic              i2s_bck;
   logic              i2s_ws;
   logic              i2s_data;
   logic [RESBIT-1:0] left_sample;
   logic [RESBIT-1:0] right_sample;
   logic [RESBIT-1:0] mono_sample;
   logic              sample_valid;
   logic              locked;
   logic              frame_err;

   modport master (
      output i2s_bck, i2s_ws, i2s_data,
      input  left_sample, right_sample, mono_sample, sample_valid, locked, frame_err
   );

   modport slave (
      input  i2s_bck, i2s_ws, i2s_data,
      output left_sample, right_sample, mono_sample, sample_valid, locked, frame_err
   );
endinterface

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples bck/ws/data, deserializes MSB-first words after the
// one-slot delay, and emits a left/right/mono pair with link-lock and error tracking.
module i2s_receiver #(
   parameter int unsigned RESBIT  = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input logic            clk,
   input logic            rst,
   i2s_receiver_if.slave  bus
);
   localparam int unsigned CW = $clog2(RESBIT + 1);

   typedef enum logic {HUNT, RECV} state_t;

   state_t            state, state_n;
   logic [2:0]        bck_sy;
   logic [1:0]        ws_sy, data_sy;
   logic              ws_prev, chan;
   logic [CW-1:0]     bit_cnt;
   logic [RESBIT-2:0] shreg;
   logic [15:0]       tmo_cnt;
   logic [RESBIT-1:0] left_hold, right_hold;
   logic              left_got, pair_go, one_ok;
   logic [RESBIT-1:0] left_q, right_q, mono_q;
   logic              valid_q, locked_q, ferr_q;

   logic              bck_rise, ws_cur, din, ws_chg, tmo_hit;
   logic              start_word, shift_en, word_done, short_err, tmo_err;
   logic [RESBIT-1:0] word;
   logic [RESBIT:0]   mono_sum;

   // ws/data are taken from the same sync stage as the bck edge so they line up
   assign bck_rise = bck_sy[1] & ~bck_sy[2];
   assign ws_cur   = ws_sy[1];
   assign din      = data_sy[1];
   assign ws_chg   = ws_cur != ws_prev;
   assign word     = {shreg, din};
   assign mono_sum = {1'b0, left_hold} + {1'b0, right_hold};
   assign tmo_hit  = (state == RECV) && !bck_rise && (tmo_cnt == 16'(TIMEOUT - 1));

   always_comb begin
      state_n    = state;
      start_word = 1'b0;
      shift_en   = 1'b0;
      word_done  = 1'b0;
      short_err  = 1'b0;
      tmo_err    = 1'b0;
      case (state)
         HUNT: begin
            if (bck_rise && ws_chg) begin
               start_word = 1'b1;
               state_n    = RECV;
            end
         end
         RECV: begin
            if (tmo_hit) begin
               tmo_err = 1'b1;
               state_n = HUNT;
            end else if (bck_rise) begin
               if (ws_chg) begin
                  start_word = 1'b1;
                  short_err  = bit_cnt < CW'(RESBIT);
               end else if (bit_cnt < CW'(RESBIT)) begin
                  shift_en  = 1'b1;
                  word_done = bit_cnt == CW'(RESBIT - 1);
               end
            end
         end
         default: state_n = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         bck_sy     <= '0;
         ws_sy      <= '0;
         data_sy    <= '0;
         ws_prev    <= 1'b0;
         chan       <= 1'b0;
         bit_cnt    <= '0;
         shreg      <= '0;
         tmo_cnt    <= '0;
         left_hold  <= '0;
         right_hold <= '0;
         left_got   <= 1'b0;
         pair_go    <= 1'b0;
         one_ok     <= 1'b0;
         left_q     <= '0;
         right_q    <= '0;
         mono_q     <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state   <= state_n;
         bck_sy  <= {bck_sy[1:0], bus.i2s_bck};
         ws_sy   <= {ws_sy[0], bus.i2s_ws};
         data_sy <= {data_sy[0], bus.i2s_data};

         if (bck_rise) begin
            ws_prev <= ws_cur;
            tmo_cnt <= '0;
         end else if (state == RECV) begin
            tmo_cnt <= tmo_cnt + 16'd1;
         end

         if (start_word || tmo_err) begin
            bit_cnt <= '0;
            chan    <= ws_cur;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= word[RESBIT-2:0];
         end

         pair_go <= word_done && chan && left_got;
         if (word_done) begin
            if (chan) begin
               right_hold <= word;
               left_got   <= 1'b0;
            end else begin
               left_hold <= word;
               left_got  <= 1'b1;
            end
         end

         valid_q <= pair_go;
         if (pair_go) begin
            left_q  <= left_hold;
            right_q <= right_hold;
            mono_q  <= mono_sum[RESBIT:1];
         end

         ferr_q <= short_err || tmo_err;
         if (short_err || tmo_err) begin
            one_ok   <= 1'b0;
            locked_q <= 1'b0;
         end else if (word_done) begin
            one_ok <= 1'b1;
            if (one_ok) locked_q <= 1'b1;
         end
      end
   end

   assign bus.left_sample  = left_q;
   assign bus.right_sample = right_q;
   assign bus.mono_sample  = mono_q;
   assign bus.sample_valid = valid_q;
   assign bus.locked       = locked_q;
   assign bus.frame_err    = ferr_q;
endmodule
